// File: rtl/be_if.sv
// Store-path bus between the E stage and the byte-enable unit.
interface be_if;
  logic [31:0] Address;
  logic [2:0]  MemOpE;
  logic        MemWriteE;
  logic [31:0] Mem_data;
  logic [3:0]  m_data_byteen;
  logic [31:0] fixed_Mem_data;
  logic        misalign;
  logic        misalign_sticky;

  modport master (
    output Address, MemOpE, MemWriteE, Mem_data,
    input  m_data_byteen, fixed_Mem_data, misalign, misalign_sticky
  );

  modport slave (
    input  Address, MemOpE, MemWriteE, Mem_data,
    output m_data_byteen, fixed_Mem_data, misalign, misalign_sticky
  );
endinterface

// File: rtl/be.sv
// Store byte-enable generator: lane enables, lane-aligned data and misalignment flags.
// Outputs are combinational except misalign_sticky, which latches any misaligned store until reset.
module be (
  input  logic clk,
  input  logic reset,
  be_if.slave  bus
);

  localparam logic [2:0] OP_WORD = 3'd0;
  localparam logic [2:0] OP_HALF = 3'd1;
  localparam logic [2:0] OP_BYTE = 3'd2;

  logic [1:0]  addr_lo;
  logic [3:0]  lanes;
  logic        bad_align;
  logic [31:0] lane_data;
  logic        sticky;
  logic        unused_addr_hi;

  assign addr_lo        = bus.Address[1:0];
  assign unused_addr_hi = ^bus.Address[31:2];

  // Lane/data decode ignores MemWriteE; the write gate is applied afterwards.
  always_comb begin
    lanes     = 4'b0000;
    bad_align = 1'b0;
    lane_data = bus.Mem_data;
    case (bus.MemOpE)
      OP_WORD: begin
        if (addr_lo == 2'd0) lanes = 4'b1111;
        else                 bad_align = 1'b1;
      end
      OP_HALF: begin
        lane_data = addr_lo[1] ? {bus.Mem_data[15:0], 16'h0000}
                               : {16'h0000, bus.Mem_data[15:0]};
        if (addr_lo[0]) bad_align = 1'b1;
        else            lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      OP_BYTE: begin
        lane_data = {24'h000000, bus.Mem_data[7:0]} << {addr_lo, 3'b000};
        lanes     = 4'b0001 << addr_lo;
      end
      default: begin
        lanes     = 4'b0000;
        bad_align = 1'b0;
      end
    endcase
  end

  assign bus.m_data_byteen   = bus.MemWriteE ? lanes : 4'b0000;
  assign bus.fixed_Mem_data  = lane_data;
  assign bus.misalign        = bus.MemWriteE & bad_align;
  assign bus.misalign_sticky = sticky;

  always_ff @(posedge clk) begin
    if (reset) sticky <= 1'b0;
    else       sticky <= sticky | bus.misalign;
  end

endmodule

// File: tb/tb_be.sv
// Directed checks of be: lane enables, lane data, misalign and sticky flag behaviour.
module tb_be;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  be_if bus ();

  be dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [2:0] op, input logic we,
                       input logic [31:0] d);
    bus.Address   = a;
    bus.MemOpE    = op;
    bus.MemWriteE = we;
    bus.Mem_data  = d;
    #1;
  endtask

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(32'h0, 3'd7, 1'b0, 32'h0);
    edge1();
    edge1();
    chk("reset_sticky", {31'b0, bus.misalign_sticky}, 32'd0);
    reset = 1'b0;

    // write disabled
    drive(32'h0, 3'd0, 1'b0, 32'hcafef00d);
    chk("nowr_byteen", {28'b0, bus.m_data_byteen}, 32'h0);
    chk("nowr_mis", {31'b0, bus.misalign}, 32'd0);
    chk("nowr_data", bus.fixed_Mem_data, 32'hcafef00d);

    // byte stores across all lanes
    drive(32'h3, 3'd2, 1'b1, 32'h0000007b);
    chk("b3_byteen", {28'b0, bus.m_data_byteen}, 32'h8);
    chk("b3_data", bus.fixed_Mem_data, 32'h7b000000);
    drive(32'h0, 3'd2, 1'b1, 32'hffffff7b);
    chk("b0_byteen", {28'b0, bus.m_data_byteen}, 32'h1);
    chk("b0_data", bus.fixed_Mem_data, 32'h0000007b);
    drive(32'h1, 3'd2, 1'b1, 32'h0000007b);
    chk("b1_byteen", {28'b0, bus.m_data_byteen}, 32'h2);
    chk("b1_data", bus.fixed_Mem_data, 32'h00007b00);
    chk("b1_mis", {31'b0, bus.misalign}, 32'd0);
    drive(32'h2, 3'd2, 1'b1, 32'h0000007b);
    chk("b2_byteen", {28'b0, bus.m_data_byteen}, 32'h4);
    chk("b2_data", bus.fixed_Mem_data, 32'h007b0000);

    // halfword stores
    drive(32'h2, 3'd1, 1'b1, 32'h1234abcd);
    chk("h2_byteen", {28'b0, bus.m_data_byteen}, 32'hc);
    chk("h2_data", bus.fixed_Mem_data, 32'habcd0000);
    drive(32'h0, 3'd1, 1'b1, 32'h1234abcd);
    chk("h0_byteen", {28'b0, bus.m_data_byteen}, 32'h3);
    chk("h0_data", bus.fixed_Mem_data, 32'h0000abcd);
    drive(32'hfffffff2, 3'd1, 1'b1, 32'h1234abcd);
    chk("hhi_byteen", {28'b0, bus.m_data_byteen}, 32'hc);
    drive(32'h2, 3'd1, 1'b0, 32'h1234abcd);
    chk("hnowr_byteen", {28'b0, bus.m_data_byteen}, 32'h0);
    chk("hnowr_data", bus.fixed_Mem_data, 32'habcd0000);

    // word store, upper address bits set
    drive(32'h4, 3'd0, 1'b1, 32'hdeadbeef);
    chk("w4_byteen", {28'b0, bus.m_data_byteen}, 32'hf);
    chk("w4_data", bus.fixed_Mem_data, 32'hdeadbeef);
    chk("w4_mis", {31'b0, bus.misalign}, 32'd0);

    // no-store opcode
    drive(32'h1, 3'd5, 1'b1, 32'h89abcdef);
    chk("op5_byteen", {28'b0, bus.m_data_byteen}, 32'h0);
    chk("op5_mis", {31'b0, bus.misalign}, 32'd0);
    chk("op5_data", bus.fixed_Mem_data, 32'h89abcdef);

    edge1();
    chk("aligned_sticky", {31'b0, bus.misalign_sticky}, 32'd0);

    // misaligned word
    drive(32'h1, 3'd0, 1'b1, 32'h55aa55aa);
    chk("w1_byteen", {28'b0, bus.m_data_byteen}, 32'h0);
    chk("w1_mis", {31'b0, bus.misalign}, 32'd1);
    chk("w1_data", bus.fixed_Mem_data, 32'h55aa55aa);
    chk("w1_sticky_pre", {31'b0, bus.misalign_sticky}, 32'd0);
    edge1();
    chk("w1_sticky", {31'b0, bus.misalign_sticky}, 32'd1);

    drive(32'h0, 3'd0, 1'b0, 32'h0);
    edge1();
    chk("sticky_hold", {31'b0, bus.misalign_sticky}, 32'd1);

    // misaligned halfword
    drive(32'h3, 3'd1, 1'b1, 32'h1234abcd);
    chk("h3_byteen", {28'b0, bus.m_data_byteen}, 32'h0);
    chk("h3_mis", {31'b0, bus.misalign}, 32'd1);
    chk("h3_data", bus.fixed_Mem_data, 32'habcd0000);

    // reset beats a simultaneous misalign
    drive(32'h1, 3'd0, 1'b1, 32'h0);
    reset = 1'b1;
    edge1();
    chk("rst_sticky", {31'b0, bus.misalign_sticky}, 32'd0);
    chk("rst_mis", {31'b0, bus.misalign}, 32'd1);
    reset = 1'b0;
    drive(32'h0, 3'd0, 1'b0, 32'h0);
    edge1();
    chk("post_rst_sticky", {31'b0, bus.misalign_sticky}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
